// File: rtl/alu_seq_exec_pkg.sv
// Shared definitions for the multi-cycle execute unit: op codes, FSM states and
// op classification helpers used by the unit and its ALU control decoder.
package alu_seq_exec_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD     = 5'b00000,
        ALU_SUB     = 5'b00001,
        ALU_XOR     = 5'b00010,
        ALU_OR      = 5'b00011,
        ALU_AND     = 5'b00100,
        ALU_SLL     = 5'b00101,
        ALU_SRL     = 5'b00110,
        ALU_SRA     = 5'b00111,
        ALU_SLT     = 5'b01000,
        ALU_SLTU    = 5'b01001,
        ALU_SLLI    = 5'b01010,
        ALU_SRLI    = 5'b01011,
        ALU_SRAI    = 5'b01100,
        ALU_EQ      = 5'b01101,
        ALU_NE      = 5'b01110,
        ALU_GE      = 5'b01111,
        ALU_GEU     = 5'b10000,
        ALU_INVALID = 5'b11111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic logic is_shift(input logic [4:0] op);
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLI, ALU_SRLI, ALU_SRAI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_left(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SLLI);
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        return (op == ALU_SRA) || (op == ALU_SRAI);
    endfunction

    // Codes above GEU are unassigned, so legality is a simple range test.
    function automatic logic is_legal(input logic [4:0] op);
        return op <= ALU_GEU;
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Operand/result valid-ready channel between the operand mux, the execute unit
// and writeback/branch logic.
interface alu_seq_exec_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_take;
    logic            illegal_op;

    modport master (
        output in_valid, alu_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, branch_take, illegal_op
    );

    modport slave (
        input  in_valid, alu_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, branch_take, illegal_op
    );

endinterface

// File: rtl/alu_seq_exec_shift_iter.sv
// Iterative shifter: shifts by SHIFT_STEP bits per cycle, finishing with the residue.
// last_step flags the cycle whose step_value is the final shifted result.
module alu_seq_exec_shift_iter
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XLEN-1:0]    start_value,
    input  logic [SHAMT_W-1:0] start_amt,
    input  logic               start_left,
    input  logic               start_arith,
    output logic [XLEN-1:0]    step_value,
    output logic               last_step
);

    localparam logic [SHAMT_W:0] STEP = (SHAMT_W + 1)'(SHIFT_STEP);

    logic [XLEN-1:0]  value_q;
    logic [SHAMT_W:0] rem_q;
    logic [SHAMT_W:0] step_amt;
    logic             left_q;
    logic             arith_q;

    always_comb begin
        step_amt = (rem_q < STEP) ? rem_q : STEP;
        if (left_q)
            step_value = value_q << step_amt;
        else if (arith_q)
            step_value = $signed(value_q) >>> step_amt;
        else
            step_value = value_q >> step_amt;
        last_step = (rem_q != '0) && (rem_q <= STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            value_q <= start_value;
            rem_q   <= {1'b0, start_amt};
            left_q  <= start_left;
            arith_q <= start_arith;
        end else if (rem_q != '0) begin
            value_q <= step_value;
            rem_q   <= rem_q - step_amt;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: one op per valid/ready transfer, iterative shifts.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_exec_if.slave  bus
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d, alu_value;
    logic               take_q, take_d, illegal_q, illegal_d;
    logic               cond, accept, go_iter;
    logic [SHAMT_W-1:0] shamt;

    assign shamt           = bus.op_b[SHAMT_W-1:0];
    assign bus.in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.result      = result_q;
    assign bus.branch_take = take_q;
    assign bus.illegal_op  = illegal_q;

    // Single-cycle datapath; in iterative mode shifts only resolve here when the amount is zero.
    always_comb begin
        alu_value = '0;
        cond      = 1'b0;
        case (bus.alu_op)
            ALU_ADD:  alu_value = bus.op_a + bus.op_b;
            ALU_SUB:  alu_value = bus.op_a - bus.op_b;
            ALU_XOR:  alu_value = bus.op_a ^ bus.op_b;
            ALU_OR:   alu_value = bus.op_a | bus.op_b;
            ALU_AND:  alu_value = bus.op_a & bus.op_b;
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL, ALU_SLLI: alu_value = bus.op_a << shamt;
            ALU_SRL, ALU_SRLI: alu_value = bus.op_a >> shamt;
            ALU_SRA, ALU_SRAI: alu_value = $signed(bus.op_a) >>> shamt;
`else
            ALU_SLL, ALU_SLLI, ALU_SRL, ALU_SRLI, ALU_SRA, ALU_SRAI: alu_value = bus.op_a;
`endif
            ALU_SLT:  cond = $signed(bus.op_a) < $signed(bus.op_b);
            ALU_SLTU: cond = bus.op_a < bus.op_b;
            ALU_EQ:   cond = bus.op_a == bus.op_b;
            ALU_NE:   cond = bus.op_a != bus.op_b;
            ALU_GE:   cond = $signed(bus.op_a) >= $signed(bus.op_b);
            ALU_GEU:  cond = bus.op_a >= bus.op_b;
            default:  alu_value = '0;
        endcase
        if (cond)
            alu_value = {{(XLEN-1){1'b0}}, 1'b1};
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign go_iter = 1'b0;
`else
    logic [XLEN-1:0] shift_value;
    logic            shift_last;

    assign go_iter = is_shift(bus.alu_op) && (shamt != '0);

    alu_seq_exec_shift_iter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_iter (
        .clk         (clk),
        .reset       (reset),
        .start       (accept && go_iter),
        .start_value (bus.op_a),
        .start_amt   (shamt),
        .start_left  (is_left(bus.alu_op)),
        .start_arith (is_arith(bus.alu_op)),
        .step_value  (shift_value),
        .last_step   (shift_last)
    );
`endif

    // DONE accepting a new op chains straight into it, giving one op per cycle.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        take_d    = take_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    result_d  = alu_value;
                    take_d    = cond;
                    illegal_d = !is_legal(bus.alu_op);
                    state_d   = go_iter ? ST_SHIFT : ST_DONE;
                end else if ((state_q == ST_DONE) && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                if (shift_last) begin
                    result_d = shift_value;
                    state_d  = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            take_q    <= take_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
